shift_exec: RTL and testbench

SHIFT_EXEC -- requirements
Module: shift_exec

---
 rtl/shift_pkg.sv | 25 ++
 rtl/shift.sv | 18 +
 rtl/shift_exec.sv | 98 +++++++++
 tb/tb_shift_exec.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared constants, the S1 payload type and the bit-reverse helper for the shift execution unit.
package shift_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [2:0] FUNCT3_SLL = 3'b001;
    localparam logic [2:0] FUNCT3_SR  = 3'b101;

    typedef struct packed {
        logic [XLEN-1:0] rs1;
        logic [4:0]      shamt;
        logic [2:0]      funct3;
        logic            funct7_5;
        logic [4:0]      rd;
    } s1_t;

    function automatic logic [XLEN-1:0] bit_rev(input logic [XLEN-1:0] v);
        logic [XLEN-1:0] r;
        for (int i = 0; i < int'(XLEN); i++) begin
            r[i] = v[XLEN-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift.sv
// Right-only barrel shifter; left shifts are built around it by bit reversal.
module shift
    import shift_pkg::*;
(
    input  logic [XLEN-1:0] data,
    input  logic [4:0]      shamt,
    input  logic            arith,
    output logic [XLEN-1:0] result
);

    logic signed [XLEN-1:0] sdata;

    always_comb begin
        sdata  = $signed(data);
        result = arith ? $unsigned(sdata >>> shamt) : (data >> shamt);
    end

endmodule

// File: rtl/shift_exec.sv
// Two-stage RV32I shift execution unit: S1 latches decoded operands, S2 holds the result.
module shift_exec
    import shift_pkg::*;
#(
    parameter bit ZERO_X0 = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic            in_funct7_5,
    input  logic            in_is_imm,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [4:0]      in_shamt_imm,
    input  logic [4:0]      in_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_result,
    output logic            out_illegal
);

    logic s1_valid, s2_valid;
    s1_t  s1_q, s1_d;
    logic s1_adv, s2_adv;

    logic            is_left, is_legal, sh_arith;
    logic [XLEN-1:0] sh_in, sh_out, res_d;

    logic unused_rs2;
    assign unused_rs2 = ^in_rs2[XLEN-1:5];

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    always_comb begin
        s1_d          = '0;
        s1_d.rs1      = in_rs1;
        s1_d.shamt    = in_is_imm ? in_shamt_imm : in_rs2[4:0];
        s1_d.funct3   = in_funct3;
        s1_d.funct7_5 = in_funct7_5;
        s1_d.rd       = in_rd;
    end

    always_comb begin
        is_left  = (s1_q.funct3 == FUNCT3_SLL);
        is_legal = (s1_q.funct3 == FUNCT3_SR) || (is_left && !s1_q.funct7_5);
        sh_arith = (s1_q.funct3 == FUNCT3_SR) && s1_q.funct7_5;
        sh_in    = is_left ? bit_rev(s1_q.rs1) : s1_q.rs1;
        res_d    = is_left ? bit_rev(sh_out) : sh_out;
        if (!is_legal || (ZERO_X0 && s1_q.rd == 5'd0)) begin
            res_d = '0;
        end
    end

    shift u_shift (
        .data   (sh_in),
        .shamt  (s1_q.shamt),
        .arith  (sh_arith),
        .result (sh_out)
    );

    // Flush only kills valids; stale data behind a cleared valid is never observed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            s1_q        <= '0;
            out_rd      <= '0;
            out_result  <= '0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_rd      <= s1_q.rd;
                    out_result  <= res_d;
                    out_illegal <= !is_legal;
                end
            end
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_q <= s1_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_exec.sv
// Directed self-checking bench for shift_exec.
module tb_shift_exec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_funct3;
    logic        in_funct7_5;
    logic        in_is_imm;
    logic [31:0] in_rs1;
    logic [31:0] in_rs2;
    logic [4:0]  in_shamt_imm;
    logic [4:0]  in_rd;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_rd;
    logic [31:0] out_result;
    logic        out_illegal;

    int total = 0;
    int bad = 0;

    shift_exec #(
        .ZERO_X0 (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_funct3    (in_funct3),
        .in_funct7_5  (in_funct7_5),
        .in_is_imm    (in_is_imm),
        .in_rs1       (in_rs1),
        .in_rs2       (in_rs2),
        .in_shamt_imm (in_shamt_imm),
        .in_rd        (in_rd),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_rd       (out_rd),
        .out_result   (out_result),
        .out_illegal  (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [4:0] rd, input logic [31:0] res,
                             input logic ill);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".rd"}, 32'(out_rd), 32'(rd));
        check({tag, ".result"}, out_result, res);
        check({tag, ".illegal"}, 32'(out_illegal), 32'(ill));
    endtask

    task automatic drive(input logic [2:0] f3, input logic f7, input logic imm,
                         input logic [31:0] rs1, input logic [31:0] rs2,
                         input logic [4:0] sh, input logic [4:0] rd);
        in_valid     = 1'b1;
        in_funct3    = f3;
        in_funct7_5  = f7;
        in_is_imm    = imm;
        in_rs1       = rs1;
        in_rs2       = rs2;
        in_shamt_imm = sh;
        in_rd        = rd;
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_funct3 = '0;
        in_funct7_5 = 1'b0;
        in_is_imm = 1'b0;
        in_rs1 = '0;
        in_rs2 = '0;
        in_shamt_imm = '0;
        in_rd = '0;
        flush = 1'b0;
        out_ready = 1'b1;

        // Reset state
        step();
        step();
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.ready", 32'(in_ready), 32'd1);
        check("rst.result", out_result, 32'd0);
        check("rst.rd", 32'(out_rd), 32'd0);
        check("rst.illegal", 32'(out_illegal), 32'd0);
        rst_n = 1'b1;
        step();

        // SLL 1 << 31, two-cycle latency
        drive(3'b001, 1'b0, 1'b0, 32'h0000_0001, 32'd31, 5'd0, 5'd5);
        step();
        in_valid = 1'b0;
        check("sll.lat1", 32'(out_valid), 32'd0);
        step();
        check_out("sll", 5'd5, 32'h8000_0000, 1'b0);
        step();
        check("sll.drain", 32'(out_valid), 32'd0);

        // SRAI then SRLI back to back
        drive(3'b101, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 5'd3);
        step();
        drive(3'b101, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 5'd4);
        step();
        in_valid = 1'b0;
        check_out("srai", 5'd3, 32'hF800_0000, 1'b0);
        step();
        check_out("srli", 5'd4, 32'h0800_0000, 1'b0);
        step();
        check("sr.drain", 32'(out_valid), 32'd0);

        // Register form: shamt 0 passthrough and upper rs2 bits ignored
        drive(3'b101, 1'b1, 1'b0, 32'h8000_0001, 32'hFFFF_FFE0, 5'd9, 5'd7);
        step();
        drive(3'b001, 1'b0, 1'b0, 32'h0000_00F1, 32'hFFFF_FFE4, 5'd0, 5'd8);
        step();
        in_valid = 1'b0;
        check_out("sra0", 5'd7, 32'h8000_0001, 1'b0);
        step();
        check_out("sllreg", 5'd8, 32'h0000_0F10, 1'b0);

        // Illegal ops and x0 destination
        drive(3'b000, 1'b0, 1'b1, 32'h0000_FFFF, 32'd0, 5'd1, 5'd2);
        step();
        drive(3'b001, 1'b1, 1'b1, 32'h0000_FFFF, 32'd0, 5'd1, 5'd6);
        step();
        drive(3'b101, 1'b0, 1'b1, 32'h0000_00F0, 32'd0, 5'd4, 5'd0);
        check_out("ill000", 5'd2, 32'd0, 1'b1);
        step();
        in_valid = 1'b0;
        check_out("ill001f7", 5'd6, 32'd0, 1'b1);
        step();
        check_out("x0", 5'd0, 32'd0, 1'b0);
        step();

        // Backpressure: out_ready low for three cycles
        out_ready = 1'b0;
        drive(3'b101, 1'b0, 1'b1, 32'h0000_0100, 32'd0, 5'd4, 5'd10);
        step();
        check("bp.ready1", 32'(in_ready), 32'd1);
        drive(3'b001, 1'b0, 1'b1, 32'h0000_0003, 32'd0, 5'd1, 5'd11);
        step();
        check("bp.ready2", 32'(in_ready), 32'd0);
        check_out("bp.a0", 5'd10, 32'h0000_0010, 1'b0);
        drive(3'b101, 1'b1, 1'b1, 32'hF000_0000, 32'd0, 5'd8, 5'd12);
        step();
        check("bp.ready3", 32'(in_ready), 32'd0);
        check_out("bp.a1", 5'd10, 32'h0000_0010, 1'b0);
        out_ready = 1'b1;
        #1;
        check("bp.readyrel", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check_out("bp.b", 5'd11, 32'h0000_0006, 1'b0);
        step();
        check_out("bp.c", 5'd12, 32'hFFF0_0000, 1'b0);
        step();
        check("bp.drain", 32'(out_valid), 32'd0);

        // Flush with both stages full; op offered on the flush cycle is dropped
        out_ready = 1'b0;
        drive(3'b101, 1'b0, 1'b1, 32'h0000_0FF0, 32'd0, 5'd4, 5'd13);
        step();
        drive(3'b101, 1'b0, 1'b1, 32'h0000_0FF0, 32'd0, 5'd8, 5'd14);
        step();
        in_valid = 1'b0;
        check("fl.full", 32'(out_valid), 32'd1);
        check("fl.ready0", 32'(in_ready), 32'd0);
        flush = 1'b1;
        drive(3'b101, 1'b0, 1'b1, 32'h0000_0FF0, 32'd0, 5'd1, 5'd20);
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("fl.valid", 32'(out_valid), 32'd0);
        check("fl.ready", 32'(in_ready), 32'd1);
        step();
        check("fl.nostale1", 32'(out_valid), 32'd0);
        step();
        check("fl.nostale2", 32'(out_valid), 32'd0);

        // Reset with both stages full
        out_ready = 1'b0;
        drive(3'b001, 1'b0, 1'b1, 32'h0000_0001, 32'd0, 5'd3, 5'd21);
        step();
        drive(3'b001, 1'b0, 1'b1, 32'h0000_0001, 32'd0, 5'd5, 5'd22);
        step();
        in_valid = 1'b0;
        check_out("rs.pre", 5'd21, 32'h0000_0008, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        check("rs.valid", 32'(out_valid), 32'd0);
        check("rs.ready", 32'(in_ready), 32'd1);
        check("rs.rd", 32'(out_rd), 32'd0);
        check("rs.result", out_result, 32'd0);
        check("rs.illegal", 32'(out_illegal), 32'd0);
        step();
        check("rs.post1", 32'(out_valid), 32'd0);
        step();
        check("rs.post2", 32'(out_valid), 32'd0);
        check("rs.post2rdy", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
